// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Multi-cycle control unit for the mini-MIPS datapath. Each instruction is
// sequenced through FETCH / DECODE / EXEC / MEM / WB, waiting on the memory
// ready handshake during instruction fetch and data access. A syscall halts
// the core. A watchdog on memory waits raises a sticky timeout and halts.
//
// Optional feature, enabled by defining MCTRL_TRAP_EN:
//   undefined opcode/fn goes to a one-cycle TRAP state that sets the sticky
//   'illegal' flag and vectors the PC (pcsrc=11, pc_we=1). When the macro is
//   undefined, such encodings retire as NOPs and 'illegal' is tied low.
//
// Parameters:
//   OP_W         opcode field width
//   FN_W         R-type function field width
//   MEM_TIMEOUT  max consecutive memory wait cycles before timeout (0 = off)
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   opcode, fn          instruction fields from IR, latched in DECODE
//   mem_ready           current fetch/load/store completes this cycle
//   if_req              instruction fetch request
//   ir_we, pc_we        IR load strobe, PC update strobe
//   regwrite, alusrc,
//   rd, we              datapath strobes (single-cycle decoder meaning)
//   pcsrc, regdst,
//   reginsrc, brtype    datapath selects (single-cycle decoder encodings)
//   state               current state, for debug
//   halted              core stopped by syscall or timeout
//   mem_timeout         sticky: watchdog expired
//   illegal             sticky: undefined opcode/fn seen
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int OP_W        = 6,
    parameter int FN_W        = 6,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] fn,
    input  logic            mem_ready,
    output logic            if_req,
    output logic            ir_we,
    output logic            pc_we,
    output logic            regwrite,
    output logic            alusrc,
    output logic            rd,
    output logic            we,
    output logic [1:0]      pcsrc,
    output logic [1:0]      regdst,
    output logic [1:0]      reginsrc,
    output logic [1:0]      brtype,
    output logic [2:0]      state,
    output logic            halted,
    output logic            mem_timeout,
    output logic            illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_ITYPE, CL_LW, CL_SW, CL_BRANCH, CL_JUMP,
        CL_RALU, CL_JR, CL_SYSCALL, CL_UNDEF
    } iclass_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_BLTZ  = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(6'b001110);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [FN_W-1:0] FN_JR    = FN_W'(6'b001000);
    localparam logic [FN_W-1:0] FN_SYS   = FN_W'(6'b001100);
    localparam logic [FN_W-1:0] FN_ADD   = FN_W'(6'b100000);
    localparam logic [FN_W-1:0] FN_SUB   = FN_W'(6'b100010);

    // Counter is wide enough to reach MEM_TIMEOUT, never narrower than 1 bit.
    localparam int              CW_RAW   = $clog2(MEM_TIMEOUT + 1);
    localparam int              CW       = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0]   TO_LIMIT = CW'(MEM_TIMEOUT);
    localparam bit              WD_EN    = (MEM_TIMEOUT > 0);

    state_t          state_q, state_next;
    logic [CW-1:0]   cnt_q, cnt_next;
    logic [OP_W-1:0] op_q;
    logic [FN_W-1:0] fn_q;
    logic            mto_q, timeout_set;
    logic            wd_expired;
    iclass_t         cls;
    logic [1:0]      br_sel;
`ifdef MCTRL_TRAP_EN
    logic            illegal_q, illegal_set;
`endif

    // Classify the latched instruction once so EXEC/MEM/WB share one decode.
    always_comb begin
        cls    = CL_UNDEF;
        br_sel = 2'b00;
        case (op_q)
            OP_RTYPE: begin
                case (fn_q)
                    FN_ADD, FN_SUB: cls = CL_RALU;
                    FN_JR:          cls = CL_JR;
                    FN_SYS:         cls = CL_SYSCALL;
                    default:        cls = CL_UNDEF;
                endcase
            end
            OP_LUI, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: cls = CL_ITYPE;
            OP_LW:   cls = CL_LW;
            OP_SW:   cls = CL_SW;
            OP_BLTZ: begin cls = CL_BRANCH; br_sel = 2'b11; end
            OP_BEQ:  begin cls = CL_BRANCH; br_sel = 2'b01; end
            OP_BNE:  begin cls = CL_BRANCH; br_sel = 2'b10; end
            OP_J:    cls = CL_JUMP;
            default: cls = CL_UNDEF;
        endcase
    end

    // Watchdog fires only while still waiting; a handshake arriving in the
    // same cycle takes priority in the next-state logic below.
    assign wd_expired = WD_EN && (cnt_q == TO_LIMIT);

    // State register, watchdog counter, instruction latch and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            op_q      <= '0;
            fn_q      <= '0;
            mto_q     <= 1'b0;
`ifdef MCTRL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            if (state_q == DECODE) begin
                op_q <= opcode;
                fn_q <= fn;
            end
            if (timeout_set) begin
                mto_q <= 1'b1;
            end
`ifdef MCTRL_TRAP_EN
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
`endif
        end
    end

    // Next-state logic and watchdog counter update.
    always_comb begin
        state_next  = state_q;
        timeout_set = 1'b0;
`ifdef MCTRL_TRAP_EN
        illegal_set = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    state_next = DECODE;
                end else if (wd_expired) begin
                    state_next  = HALT;
                    timeout_set = 1'b1;
                end
            end
            DECODE: state_next = EXEC;
            EXEC: begin
                case (cls)
                    CL_ITYPE, CL_RALU: state_next = WB;
                    CL_LW, CL_SW:      state_next = MEM;
                    CL_SYSCALL:        state_next = HALT;
`ifdef MCTRL_TRAP_EN
                    CL_UNDEF: begin
                        state_next  = TRAP;
                        illegal_set = 1'b1;
                    end
`endif
                    default:           state_next = FETCH;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    state_next = (cls == CL_LW) ? WB : FETCH;
                end else if (wd_expired) begin
                    state_next  = HALT;
                    timeout_set = 1'b1;
                end
            end
            WB:      state_next = FETCH;
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase

        cnt_next = cnt_q;
        if (state_next != state_q) begin
            cnt_next = '0;
        end else if ((state_q == FETCH || state_q == MEM) && !mem_ready
                     && (cnt_q != {CW{1'b1}})) begin
            cnt_next = cnt_q + CW'(1);
        end
    end

    // Moore outputs from state and latched instruction; only the FETCH
    // strobes look at mem_ready. Everything is forced low while in reset.
    always_comb begin
        if_req   = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        regwrite = 1'b0;
        alusrc   = 1'b0;
        rd       = 1'b0;
        we       = 1'b0;
        pcsrc    = 2'b00;
        regdst   = 2'b00;
        reginsrc = 2'b00;
        brtype   = 2'b00;
        halted   = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    if_req = 1'b1;
                    ir_we  = mem_ready;
                    pc_we  = mem_ready;
                end
                EXEC: begin
                    case (cls)
                        CL_ITYPE, CL_LW, CL_SW: alusrc = 1'b1;
                        CL_BRANCH:  begin pc_we = 1'b1; brtype = br_sel; end
                        CL_JUMP:    begin pc_we = 1'b1; pcsrc = 2'b01;   end
                        CL_JR:      begin pc_we = 1'b1; pcsrc = 2'b10;   end
                        CL_SYSCALL: begin pc_we = 1'b1; pcsrc = 2'b11;   end
                        default: ;
                    endcase
                end
                MEM: begin
                    alusrc = 1'b1;
                    rd     = (cls == CL_LW);
                    we     = (cls == CL_SW);
                end
                WB: begin
                    regwrite = 1'b1;
                    case (cls)
                        CL_LW:   begin regdst = 2'b00; reginsrc = 2'b00; end
                        CL_RALU: begin regdst = 2'b01; reginsrc = 2'b01; end
                        default: begin regdst = 2'b00; reginsrc = 2'b01; end
                    endcase
                end
                HALT: halted = 1'b1;
`ifdef MCTRL_TRAP_EN
                TRAP: begin
                    pc_we = 1'b1;
                    pcsrc = 2'b11;
                end
`endif
                default: ;
            endcase
        end
    end

    assign state       = rst_n ? state_q : 3'b000;
    assign mem_timeout = mto_q & rst_n;
`ifdef MCTRL_TRAP_EN
    assign illegal     = illegal_q & rst_n;
`else
    assign illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Two controllers share the same inputs: dut_a with MEM_TIMEOUT=15 and
// dut_b with MEM_TIMEOUT=4. A transaction-level reference model expands each
// instruction into its expected per-cycle outputs (fetch waits, decode,
// execute, memory waits, write-back), and random wait states and IR noise
// outside DECODE are driven alongside. Waits of up to 4 cycles hit dut_b's
// watchdog boundary where the handshake must win. A directed tail covers
// syscall halt, asynchronous reset mid-HALT and a stuck-fetch timeout.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    // Strobe bits: {if_req, ir_we, pc_we, regwrite, alusrc, rd, we}
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_IF   = 7'b1000000;
    localparam logic [6:0] S_IRW  = 7'b0100000;
    localparam logic [6:0] S_PCW  = 7'b0010000;
    localparam logic [6:0] S_RW   = 7'b0001000;
    localparam logic [6:0] S_ALU  = 7'b0000100;
    localparam logic [6:0] S_RD   = 7'b0000010;
    localparam logic [6:0] S_WE   = 7'b0000001;
    localparam logic [20:0] MTO_BIT = 21'b10;

    localparam int C_ITYPE = 0, C_LW = 1, C_SW = 2, C_BR = 3, C_J = 4,
                   C_RALU = 5, C_JR = 6, C_SYS = 7, C_BAD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, fn;
    logic       mem_ready;

    logic       if_req_a, ir_we_a, pc_we_a, regwrite_a, alusrc_a, rd_a, we_a;
    logic [1:0] pcsrc_a, regdst_a, reginsrc_a, brtype_a;
    logic [2:0] state_a;
    logic       halted_a, mem_timeout_a, illegal_a;
    logic       if_req_b, ir_we_b, pc_we_b, regwrite_b, alusrc_b, rd_b, we_b;
    logic [1:0] pcsrc_b, regdst_b, reginsrc_b, brtype_b;
    logic [2:0] state_b;
    logic       halted_b, mem_timeout_b, illegal_b;

    logic [20:0] obs_a, obs_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit ill_seen = 1'b0;

    typedef struct {
        logic        ready;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [20:0] exp;
    } cyc_t;
    cyc_t q[$];

    logic [5:0] tbl_op [16] = '{6'b001111, 6'b001000, 6'b001100, 6'b001101,
                                6'b001110, 6'b100011, 6'b101011, 6'b000001,
                                6'b000010, 6'b000101, 6'b000100, 6'b000000,
                                6'b000000, 6'b000000, 6'b111111, 6'b000000};
    logic [5:0] tbl_fn [16] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                6'b000000, 6'b000000, 6'b000000, 6'b100000,
                                6'b100010, 6'b001000, 6'b000000, 6'b000111};

    multicycle_controller #(.OP_W(6), .FN_W(6), .MEM_TIMEOUT(15)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .fn(fn), .mem_ready(mem_ready),
        .if_req(if_req_a), .ir_we(ir_we_a), .pc_we(pc_we_a), .regwrite(regwrite_a),
        .alusrc(alusrc_a), .rd(rd_a), .we(we_a), .pcsrc(pcsrc_a), .regdst(regdst_a),
        .reginsrc(reginsrc_a), .brtype(brtype_a), .state(state_a), .halted(halted_a),
        .mem_timeout(mem_timeout_a), .illegal(illegal_a)
    );

    multicycle_controller #(.OP_W(6), .FN_W(6), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .fn(fn), .mem_ready(mem_ready),
        .if_req(if_req_b), .ir_we(ir_we_b), .pc_we(pc_we_b), .regwrite(regwrite_b),
        .alusrc(alusrc_b), .rd(rd_b), .we(we_b), .pcsrc(pcsrc_b), .regdst(regdst_b),
        .reginsrc(reginsrc_b), .brtype(brtype_b), .state(state_b), .halted(halted_b),
        .mem_timeout(mem_timeout_b), .illegal(illegal_b)
    );

    assign obs_a = {state_a, if_req_a, ir_we_a, pc_we_a, regwrite_a, alusrc_a, rd_a, we_a,
                    pcsrc_a, regdst_a, reginsrc_a, brtype_a, halted_a, mem_timeout_a, illegal_a};
    assign obs_b = {state_b, if_req_b, ir_we_b, pc_we_b, regwrite_b, alusrc_b, rd_b, we_b,
                    pcsrc_b, regdst_b, reginsrc_b, brtype_b, halted_b, mem_timeout_b, illegal_b};

    // 10 ns clock
    always #5 clk = ~clk;

    // Expected output vector; mem_timeout is 0 here (OR in MTO_BIT when set)
    // and illegal follows the model's sticky flag.
    function automatic logic [20:0] v(input logic [2:0] st, input logic [6:0] strb,
                                      input logic [1:0] pcs, input logic [1:0] rdst,
                                      input logic [1:0] rin, input logic [1:0] brt,
                                      input logic hlt);
        return {st, strb, pcs, rdst, rin, brt, hlt, 1'b0, ill_seen};
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] f);
        case (op)
            6'b001111, 6'b001000, 6'b001100, 6'b001101, 6'b001110: return C_ITYPE;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000001, 6'b000010, 6'b000101: return C_BR;
            6'b000100: return C_J;
            6'b000000: begin
                case (f)
                    6'b100000, 6'b100010: return C_RALU;
                    6'b001000: return C_JR;
                    6'b001100: return C_SYS;
                    default:   return C_BAD;
                endcase
            end
            default: return C_BAD;
        endcase
    endfunction

    function automatic logic [1:0] branch_type(input logic [5:0] op);
        if (op == 6'b000001) return 2'b11;
        if (op == 6'b000010) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic push(input logic rdy, input logic [5:0] op, input logic [5:0] f,
                        input logic [20:0] e);
        cyc_t c;
        c.ready = rdy;
        c.op    = op;
        c.fn    = f;
        c.exp   = e;
        q.push_back(c);
    endtask

    // Expand one instruction into its expected cycles. fw/mw are the number
    // of wait cycles before mem_ready rises in fetch and in the data access.
    task automatic addInstr(input logic [5:0] op, input logic [5:0] f,
                            input int fw, input int mw);
        int c;
        c = classify(op, f);
        for (int i = 0; i < fw; i++)
            push(1'b0, rnd6(), rnd6(), v(ST_FETCH, S_IF, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        push(1'b1, rnd6(), rnd6(),
             v(ST_FETCH, S_IF | S_IRW | S_PCW, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        push(1'($urandom_range(0, 1)), op, f,
             v(ST_DECODE, S_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        case (c)
            C_ITYPE, C_LW, C_SW:
                push(1'($urandom_range(0, 1)), rnd6(), rnd6(),
                     v(ST_EXEC, S_ALU, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
            C_BR:
                push(1'($urandom_range(0, 1)), rnd6(), rnd6(),
                     v(ST_EXEC, S_PCW, 2'b00, 2'b00, 2'b00, branch_type(op), 1'b0));
            C_J:
                push(1'($urandom_range(0, 1)), rnd6(), rnd6(),
                     v(ST_EXEC, S_PCW, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0));
            C_JR:
                push(1'($urandom_range(0, 1)), rnd6(), rnd6(),
                     v(ST_EXEC, S_PCW, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0));
            C_SYS:
                push(1'($urandom_range(0, 1)), rnd6(), rnd6(),
                     v(ST_EXEC, S_PCW, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0));
            default:
                push(1'($urandom_range(0, 1)), rnd6(), rnd6(),
                     v(ST_EXEC, S_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        endcase
        if (c == C_LW || c == C_SW) begin
            for (int i = 0; i <= mw; i++)
                push((i == mw), rnd6(), rnd6(),
                     v(ST_MEM, S_ALU | ((c == C_LW) ? S_RD : S_WE),
                       2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        end
        case (c)
            C_ITYPE:
                push(1'($urandom_range(0, 1)), rnd6(), rnd6(),
                     v(ST_WB, S_RW, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
            C_LW:
                push(1'($urandom_range(0, 1)), rnd6(), rnd6(),
                     v(ST_WB, S_RW, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
            C_RALU:
                push(1'($urandom_range(0, 1)), rnd6(), rnd6(),
                     v(ST_WB, S_RW, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0));
            default: ;
        endcase
`ifdef MCTRL_TRAP_EN
        if (c == C_BAD) begin
            ill_seen = 1'b1;
            push(1'($urandom_range(0, 1)), rnd6(), rnd6(),
                 v(ST_TRAP, S_PCW, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0));
        end
`endif
    endtask

    task automatic checkOutput(input string tag, input logic [20:0] obs,
                               input logic [20:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Play the queued cycles; entered and left just after a rising edge.
    task automatic applyStimulus();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready = c.ready;
            opcode    = c.op;
            fn        = c.fn;
            @(negedge clk);
            checkOutput($sformatf("A cyc%0d", cyc), obs_a, c.exp);
            checkOutput($sformatf("B cyc%0d", cyc), obs_b, c.exp);
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b001000;
        fn        = 6'b000000;
        repeat (2) @(negedge clk);
        checkOutput("A in reset", obs_a, 21'b0);
        checkOutput("B in reset", obs_b, 21'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed opening: addi, lw with 3 memory waits, beq, j, jr, bad op
        addInstr(6'b001000, rnd6(), 0, 0);
        addInstr(6'b100011, rnd6(), 0, 3);
        addInstr(6'b000010, rnd6(), 0, 0);
        addInstr(6'b000100, rnd6(), 0, 0);
        addInstr(6'b000000, 6'b001000, 0, 0);
        addInstr(6'b111111, rnd6(), 0, 0);
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 15);
            addInstr(tbl_op[k], (tbl_op[k] == 6'b000000) ? tbl_fn[k] : rnd6(),
                     $urandom_range(0, 4), $urandom_range(0, 4));
        end
        addInstr(6'b000000, 6'b001100, $urandom_range(0, 2), 0);
        for (int i = 0; i < 4; i++)
            push(1'($urandom_range(0, 1)), rnd6(), rnd6(),
                 v(ST_HALT, S_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
        applyStimulus();

        // Asynchronous reset in the middle of a HALT cycle
        #3;
        rst_n = 1'b0;
        #1;
        ill_seen = 1'b0;
        checkOutput("A async reset", obs_a, 21'b0);
        checkOutput("B async reset", obs_b, 21'b0);
        @(negedge clk);
        checkOutput("B held reset", obs_b, 21'b0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b0;

        // Fetch stuck: dut_b times out after 5 FETCH cycles, dut_a keeps waiting
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("A stuck%0d", i), obs_a,
                        v(ST_FETCH, S_IF, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
            checkOutput($sformatf("B stuck%0d", i), obs_b,
                        v(ST_FETCH, S_IF, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("A no timeout", obs_a,
                    v(ST_FETCH, S_IF, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        checkOutput("B timeout", obs_b,
                    v(ST_HALT, S_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1) | MTO_BIT);
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("B late ready%0d", i), obs_b,
                        v(ST_HALT, S_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1) | MTO_BIT);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("B timeout cleared", obs_b, 21'b0);
        #10;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
